// File: rtl/ecg_sram_pkg.sv
// Shared types and constants for the ECG sample capture path into SRAM port 2.
package ecg_sram_pkg;

  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SAMPLE_W = DATA_W / 2;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_LOW  = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_e;

endpackage

// File: rtl/sample_packer.sv
// Packs pairs of 16-bit samples into 32-bit words, low half first; a flush
// emits a lone pending sample with the upper half zeroed.
module sample_packer #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DATA_W   = 2 * SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear_i,
  input  logic                accept_i,
  input  logic [SAMPLE_W-1:0] data_i,
  input  logic                flush_i,
  output logic                word_valid_o,
  output logic [DATA_W-1:0]   word_data_o,
  output logic [3:0]          word_be_o,
  output logic                flush_req_o
);
  import ecg_sram_pkg::*;

  logic                pending_q, pending_d;
  logic [SAMPLE_W-1:0] low_q, low_d;

  always_comb begin
    pending_d    = pending_q;
    low_d        = low_q;
    word_valid_o = 1'b0;
    word_data_o  = '0;
    word_be_o    = '0;
    if (clear_i) begin
      pending_d = 1'b0;
    end else if (flush_i) begin
      if (pending_q) begin
        word_valid_o = 1'b1;
        word_data_o  = {{SAMPLE_W{1'b0}}, low_q};
        word_be_o    = BE_LOW;
      end
      pending_d = 1'b0;
    end else if (accept_i) begin
      if (pending_q) begin
        word_valid_o = 1'b1;
        word_data_o  = {data_i, low_q};
        word_be_o    = BE_FULL;
        pending_d    = 1'b0;
      end else begin
        low_d     = data_i;
        pending_d = 1'b1;
      end
    end
  end

  // Pending state after this cycle's accept: tells the FSM whether a stop needs a flush.
  assign flush_req_o = pending_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      low_q     <= '0;
    end else begin
      pending_q <= pending_d;
      low_q     <= low_d;
    end
  end

endmodule

// File: rtl/ecg_sample_sram_writer.sv
// Capture FSM, frame/address counters and registered SRAM port-2 write
// interface for packed ECG samples; single-shot or circular frame region.
module ecg_sample_sram_writer #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                circular,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     frame_words,
  input  logic [SAMPLE_W-1:0] snk_data,
  input  logic                snk_valid,
  output logic                snk_ready,
  output logic [ADDR_W-1:0]   sram_address,
  output logic                sram_chipselect,
  output logic                sram_write,
  output logic [3:0]          sram_byteenable,
  output logic [DATA_W-1:0]   sram_writedata,
  output logic [ADDR_W-1:0]   wr_ptr,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          wrap_count
);
  import ecg_sram_pkg::*;

  localparam int unsigned FW_W = ADDR_W + 1;

  state_e              state_q, state_d;
  logic                circ_q, circ_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [FW_W-1:0]     frame_q, frame_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]          wrap_q, wrap_d;
  logic                cs_q, cs_d;
  logic [3:0]          be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;

  logic                accept;
  logic                restart;
  logic                frame_end;
  logic                word_valid;
  logic [DATA_W-1:0]   word_data;
  logic [3:0]          word_be;
  logic                flush_req;

  assign snk_ready = (state_q == RUN);
  assign accept    = snk_valid && snk_ready;
  assign restart   = start && !stop && (state_q == IDLE || state_q == DONE);
  // frame_q holds the effective length (0 already mapped to 2**ADDR_W), hence the extra bit.
  assign frame_end = ({1'b0, wr_ptr_q} + FW_W'(1)) == frame_q;

  sample_packer #(
    .SAMPLE_W (SAMPLE_W),
    .DATA_W   (DATA_W)
  ) u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (restart),
    .accept_i     (accept),
    .data_i       (snk_data),
    .flush_i      (state_q == FLUSH),
    .word_valid_o (word_valid),
    .word_data_o  (word_data),
    .word_be_o    (word_be),
    .flush_req_o  (flush_req)
  );

  always_comb begin
    state_d  = state_q;
    circ_d   = circ_q;
    base_d   = base_q;
    frame_d  = frame_q;
    wr_ptr_d = wr_ptr_q;
    wrap_d   = wrap_q;
    cs_d     = 1'b0;
    be_d     = '0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d  = RUN;
          circ_d   = circular;
          base_d   = base_addr;
          frame_d  = (frame_words == '0) ? {1'b1, {ADDR_W{1'b0}}} : frame_words;
          wr_ptr_d = '0;
          wrap_d   = '0;
        end
      end
      RUN: begin
        if (stop) state_d = flush_req ? FLUSH : IDLE;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Words only appear in RUN or FLUSH, so this never collides with a restart.
    if (word_valid) begin
      cs_d    = 1'b1;
      be_d    = word_be;
      wdata_d = word_data;
      addr_d  = base_q + wr_ptr_q;
      if (frame_end) begin
        done_d   = 1'b1;
        wrap_d   = wrap_q + 8'd1;
        wr_ptr_d = '0;
        if (!circ_q && state_q == RUN && !stop) state_d = DONE;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      circ_q   <= 1'b0;
      base_q   <= '0;
      frame_q  <= '0;
      wr_ptr_q <= '0;
      wrap_q   <= '0;
      cs_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      circ_q   <= circ_d;
      base_q   <= base_d;
      frame_q  <= frame_d;
      wr_ptr_q <= wr_ptr_d;
      wrap_q   <= wrap_d;
      cs_q     <= cs_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  end

  assign sram_address    = addr_q;
  assign sram_chipselect = cs_q;
  assign sram_write      = cs_q;
  assign sram_byteenable = be_q;
  assign sram_writedata  = wdata_q;
  assign wr_ptr          = wr_ptr_q;
  assign busy            = (state_q != IDLE);
  assign frame_done      = done_q;
  assign wrap_count      = wrap_q;

endmodule

// File: tb/tb_ecg_sample_sram_writer.sv
// Randomized self-checking bench; expected SRAM writes come from a frame/pair arithmetic model.
module tb_ecg_sample_sram_writer;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          circular = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   frame_words = '0;
  logic [SW-1:0] snk_data = '0;
  logic          snk_valid = 1'b0;
  logic          snk_ready;
  logic [AW-1:0] sram_address;
  logic          sram_chipselect;
  logic          sram_write;
  logic [3:0]    sram_byteenable;
  logic [DW-1:0] sram_writedata;
  logic [AW-1:0] wr_ptr;
  logic          busy;
  logic          frame_done;
  logic [7:0]    wrap_count;

  ecg_sample_sram_writer #(
    .ADDR_W   (AW),
    .SAMPLE_W (SW),
    .DATA_W   (DW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .stop            (stop),
    .circular        (circular),
    .base_addr       (base_addr),
    .frame_words     (frame_words),
    .snk_data        (snk_data),
    .snk_valid       (snk_valid),
    .snk_ready       (snk_ready),
    .sram_address    (sram_address),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_byteenable (sram_byteenable),
    .sram_writedata  (sram_writedata),
    .wr_ptr          (wr_ptr),
    .busy            (busy),
    .frame_done      (frame_done),
    .wrap_count      (wrap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    be;
    logic          fd;
    logic [7:0]    wc;
  } wr_t;

  wr_t           got_q[$];
  wr_t           exp_q[$];
  int            acc_cyc_q[$];
  logic [SW-1:0] smp_q[$];
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  int            strobe_err = 0;
  int            fd_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t r;
    if (snk_valid && snk_ready) acc_cyc_q.push_back(cyc);
    if (sram_write) begin
      r.cyc = cyc; r.addr = sram_address; r.data = sram_writedata;
      r.be = sram_byteenable; r.fd = frame_done; r.wc = wrap_count;
      got_q.push_back(r);
    end
    if (reset_n && (sram_chipselect !== sram_write || (!sram_write && sram_byteenable !== 4'b0000)))
      strobe_err++;
    if (frame_done && !sram_write) fd_err++;
  end

  // Reference: word k holds samples 2k (low) and 2k+1 (high); its frame offset is
  // k mod frame length in circular mode; an odd trailing sample becomes a half word.
  function automatic void build_exp(input logic [AW-1:0] base, input int fw, input bit circ);
    int  nw;
    int  off;
    int  frames;
    wr_t r;
    exp_q.delete();
    frames = 0;
    nw = (smp_q.size() + 1) / 2;
    for (int k = 0; k < nw; k++) begin
      off    = circ ? (k % fw) : k;
      r.cyc  = 0;
      r.addr = base + AW'(off);
      if (2 * k + 1 < smp_q.size()) begin
        r.data = {smp_q[2*k+1], smp_q[2*k]};
        r.be   = 4'hF;
      end else begin
        r.data = {16'h0000, smp_q[2*k]};
        r.be   = 4'h3;
      end
      r.fd = (off == fw - 1);
      if (r.fd) frames++;
      r.wc = 8'(frames);
      exp_q.push_back(r);
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    got_q.delete(); acc_cyc_q.delete(); smp_q.delete();
  endtask

  task automatic start_cap(input logic [AW-1:0] base, input logic [AW:0] fw, input bit circ);
    base_addr = base; frame_words = fw; circular = circ; start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic send(input bit bubbles, input bit stop_with_last);
    for (int i = 0; i < smp_q.size(); i++) begin
      snk_data  = smp_q[i];
      snk_valid = 1'b1;
      stop      = stop_with_last && (i == smp_q.size() - 1);
      cycles(1);
      snk_valid = 1'b0;
      stop      = 1'b0;
      if (bubbles) cycles(1);
    end
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    cycles(3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cycles(2);
    tests++;
    if ({snk_ready, sram_address, sram_chipselect, sram_write, sram_byteenable, sram_writedata,
         wr_ptr, busy, frame_done, wrap_count} !== '0) begin
      fails++; $display("FAIL reset_outputs: some output nonzero, busy=%b wr_ptr=%h", busy, wr_ptr);
    end
    reset_n = 1'b1;
    cycles(1);
    clear_logs();
    for (int i = 0; i < 3; i++) smp_q.push_back(SW'($urandom));
    start_cap(14'h0040, 15'd8, 1'b0);
    send(1'b0, 1'b0);
    tests++;
    if (busy !== 1'b1 || snk_ready !== 1'b1) begin
      fails++; $display("FAIL reset_pre_run: busy=%b ready=%b, required 1 1", busy, snk_ready);
    end
    reset_n = 1'b0;
    got_q.delete();
    cycles(1);
    tests++;
    if ({snk_ready, sram_address, sram_chipselect, sram_write, sram_byteenable, sram_writedata,
         wr_ptr, busy, frame_done, wrap_count} !== '0) begin
      fails++; $display("FAIL reset_mid_run: outputs not zero, busy=%b we=%b wr_ptr=%h", busy, sram_write, wr_ptr);
    end
    cycles(1);
    reset_n = 1'b1;
    cycles(2);
    tests++;
    if (got_q.size() != 0) begin
      fails++; $display("FAIL reset_no_flush: %0d writes seen, required 0", got_q.size());
    end
    clear_logs();
    for (int i = 0; i < 2; i++) smp_q.push_back(SW'($urandom));
    start_cap(14'h0123, 15'd8, 1'b0);
    send(1'b0, 1'b0);
    cycles(2);
    build_exp(14'h0123, 8, 1'b0);
    tests++;
    if (got_q.size() != 1 || got_q[0].addr !== exp_q[0].addr || got_q[0].data !== exp_q[0].data
        || wr_ptr !== 14'd1) begin
      fails++; $display("FAIL reset_restart: nwr=%0d wr_ptr=%h, required 1 write at %h data %h, wr_ptr 1",
                        got_q.size(), wr_ptr, exp_q[0].addr, exp_q[0].data);
    end
    pulse_stop();
  endtask

  task automatic test_single_shot();
    clear_logs();
    for (int i = 1; i <= 8; i++) smp_q.push_back(SW'(i));
    start_cap(14'h0100, 15'd4, 1'b0);
    send(1'b0, 1'b0);
    cycles(3);
    build_exp(14'h0100, 4, 1'b0);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL ss_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data || got_q[i].be !== exp_q[i].be
          || got_q[i].fd !== exp_q[i].fd || got_q[i].wc !== exp_q[i].wc) begin
        fails++; $display("FAIL ss_write[%0d]: got %h/%h/%h/%b/%0d required %h/%h/%h/%b/%0d", i,
          got_q[i].addr, got_q[i].data, got_q[i].be, got_q[i].fd, got_q[i].wc,
          exp_q[i].addr, exp_q[i].data, exp_q[i].be, exp_q[i].fd, exp_q[i].wc);
      end
    end
    tests++;
    if (busy !== 1'b1 || snk_ready !== 1'b0 || wrap_count !== 8'd1) begin
      fails++; $display("FAIL ss_done: busy=%b ready=%b wrap=%0d, required 1 0 1", busy, snk_ready, wrap_count);
    end
    clear_logs();
    for (int i = 0; i < 2; i++) smp_q.push_back(SW'($urandom));
    start_cap(14'h0800, 15'd2, 1'b0);
    send(1'b0, 1'b0);
    cycles(2);
    build_exp(14'h0800, 2, 1'b0);
    tests++;
    if (got_q.size() != 1 || got_q[0].addr !== exp_q[0].addr || got_q[0].data !== exp_q[0].data
        || got_q[0].wc !== 8'd0 || wr_ptr !== 14'd1) begin
      fails++; $display("FAIL ss_restart_from_done: nwr=%0d wr_ptr=%h, required 1 write at %h data %h wc 0",
                        got_q.size(), wr_ptr, exp_q[0].addr, exp_q[0].data);
    end
    pulse_stop();
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL ss_stop_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_circular();
    int fds;
    clear_logs();
    for (int i = 0; i < 12; i++) smp_q.push_back(SW'($urandom));
    start_cap(14'h3FFE, 15'd3, 1'b1);
    send(1'b0, 1'b0);
    cycles(2);
    build_exp(14'h3FFE, 3, 1'b1);
    fds = 0;
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL circ_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i].fd) fds++;
      tests++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data || got_q[i].be !== exp_q[i].be
          || got_q[i].fd !== exp_q[i].fd || got_q[i].wc !== exp_q[i].wc) begin
        fails++; $display("FAIL circ_write[%0d]: got %h/%h/%h/%b/%0d required %h/%h/%h/%b/%0d", i,
          got_q[i].addr, got_q[i].data, got_q[i].be, got_q[i].fd, got_q[i].wc,
          exp_q[i].addr, exp_q[i].data, exp_q[i].be, exp_q[i].fd, exp_q[i].wc);
      end
    end
    tests++;
    if (wrap_count !== 8'd2 || fds != 2 || wr_ptr !== 14'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL circ_state: wrap=%0d pulses=%0d wr_ptr=%h busy=%b, required 2 2 0 1",
                        wrap_count, fds, wr_ptr, busy);
    end
    pulse_stop();
    for (int t = 0; t < 4; t++) begin
      logic [AW-1:0] b;
      int            fw;
      bit            bub;
      bit            swl;
      clear_logs();
      b   = AW'($urandom);
      fw  = $urandom_range(1, 5);
      bub = 1'($urandom);
      swl = 1'($urandom);
      for (int i = 0; i < int'($urandom_range(5, 21)); i++) smp_q.push_back(SW'($urandom));
      start_cap(b, 15'(fw), 1'b1);
      send(bub, swl);
      if (!swl) pulse_stop(); else cycles(4);
      build_exp(b, fw, 1'b1);
      tests++;
      if (got_q.size() != exp_q.size()) begin
        fails++; $display("FAIL circ_rand%0d_count: got %0d writes, required %0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        tests++;
        if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data || got_q[i].be !== exp_q[i].be
            || got_q[i].fd !== exp_q[i].fd || got_q[i].wc !== exp_q[i].wc) begin
          fails++; $display("FAIL circ_rand%0d_write[%0d]: got %h/%h/%h/%b/%0d required %h/%h/%h/%b/%0d", t, i,
            got_q[i].addr, got_q[i].data, got_q[i].be, got_q[i].fd, got_q[i].wc,
            exp_q[i].addr, exp_q[i].data, exp_q[i].be, exp_q[i].fd, exp_q[i].wc);
        end
      end
      tests++;
      if (wr_ptr !== AW'(exp_q.size() % fw) || busy !== 1'b0) begin
        fails++; $display("FAIL circ_rand%0d_end: wr_ptr=%h busy=%b, required %h 0", t, wr_ptr, busy,
                          AW'(exp_q.size() % fw));
      end
    end
  endtask

  task automatic test_odd_stop();
    logic [SW-1:0] fixed_s[3];
    fixed_s[0] = 16'hAAAA; fixed_s[1] = 16'hBBBB; fixed_s[2] = 16'hCCCC;
    for (int v = 0; v < 3; v++) begin
      logic [AW-1:0] b;
      int            fw;
      bit            circ;
      clear_logs();
      b    = (v == 0) ? 14'h0200 : AW'($urandom);
      fw   = (v == 0) ? 8 : 3;
      circ = (v != 0);
      if (v == 0) for (int i = 0; i < 3; i++) smp_q.push_back(fixed_s[i]);
      else for (int i = 0; i < 4 + v; i++) smp_q.push_back(SW'($urandom));
      start_cap(b, 15'(fw), circ);
      send(1'b0, v != 0);
      if (v == 0) pulse_stop(); else cycles(4);
      build_exp(b, fw, circ);
      tests++;
      if (got_q.size() != exp_q.size()) begin
        fails++; $display("FAIL stop%0d_count: got %0d writes, required %0d", v, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        tests++;
        if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data || got_q[i].be !== exp_q[i].be
            || got_q[i].fd !== exp_q[i].fd || got_q[i].wc !== exp_q[i].wc) begin
          fails++; $display("FAIL stop%0d_write[%0d]: got %h/%h/%h/%b/%0d required %h/%h/%h/%b/%0d", v, i,
            got_q[i].addr, got_q[i].data, got_q[i].be, got_q[i].fd, got_q[i].wc,
            exp_q[i].addr, exp_q[i].data, exp_q[i].be, exp_q[i].fd, exp_q[i].wc);
        end
      end
      tests++;
      if (busy !== 1'b0 || snk_ready !== 1'b0) begin
        fails++; $display("FAIL stop%0d_idle: busy=%b ready=%b, required 0 0", v, busy, snk_ready);
      end
    end
  endtask

  task automatic test_bubbles();
    clear_logs();
    for (int i = 0; i < 8; i++) smp_q.push_back(SW'($urandom));
    start_cap(14'h1000, 15'd16, 1'b0);
    send(1'b1, 1'b0);
    pulse_stop();
    build_exp(14'h1000, 16, 1'b0);
    tests++;
    if (got_q.size() != 4 || acc_cyc_q.size() != 8) begin
      fails++; $display("FAIL bub_count: got %0d writes %0d accepts, required 4 8", got_q.size(), acc_cyc_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size() && 2 * i + 1 < acc_cyc_q.size(); i++) begin
      tests++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].addr !== exp_q[i].addr
          || got_q[i].cyc != acc_cyc_q[2*i+1] + 1) begin
        fails++; $display("FAIL bub_write[%0d]: got %h@%h cyc %0d required %h@%h cyc %0d", i,
          got_q[i].data, got_q[i].addr, got_q[i].cyc, exp_q[i].data, exp_q[i].addr, acc_cyc_q[2*i+1] + 1);
      end
    end
  endtask

  task automatic test_start_stop_idle();
    clear_logs();
    start = 1'b1; stop = 1'b1; base_addr = 14'h0010; frame_words = 15'd2; circular = 1'b1;
    snk_valid = 1'b1; snk_data = 16'h1234;
    cycles(1);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (busy !== 1'b0 || snk_ready !== 1'b0) begin
        fails++; $display("FAIL ss_idle_c%0d: busy=%b ready=%b, required 0 0", i, busy, snk_ready);
      end
      cycles(1);
    end
    snk_valid = 1'b0;
    tests++;
    if (got_q.size() != 0 || acc_cyc_q.size() != 0) begin
      fails++; $display("FAIL ss_idle_nowrite: %0d writes %0d accepts, required 0 0", got_q.size(), acc_cyc_q.size());
    end
  endtask

  task automatic test_strobes();
    tests++;
    if (strobe_err != 0) begin
      fails++; $display("FAIL strobes: %0d cycles with inconsistent cs/we/be, required 0", strobe_err);
    end
    tests++;
    if (fd_err != 0) begin
      fails++; $display("FAIL frame_done_alone: %0d pulses without a write, required 0", fd_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_circular();
    test_odd_stop();
    test_bubbles();
    test_start_stop_idle();
    test_strobes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
